// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped instruction cache with 16-byte block refill.
// Optional hit/miss counters are enabled with `define ICACHE_STATS_EN.
module icache_fetch #(
  parameter int INDEX_W = 3,
  parameter int ADDR_W  = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       PC,
  output logic [31:0]       INSTRUCTION,
  output logic              BUSYWAIT,
  output logic              MEM_READ,
  output logic [ADDR_W-5:0] MEM_ADDRESS,
  input  logic [127:0]      MEM_READDATA,
  input  logic              MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]       HIT_COUNT,
  output logic [15:0]       MISS_COUNT
`endif
);
  localparam int TAG_W = ADDR_W - INDEX_W - 4;
  localparam int NB = 1 << INDEX_W;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_UPDATE} state_t;
  state_t r_state, w_next;
  logic [NB-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [NB];
  logic [3:0][31:0] r_data [NB];
  logic [ADDR_W-5:0] r_miss;
  logic [INDEX_W-1:0] w_index, w_miss_idx;
  logic [TAG_W-1:0] w_tag;
  logic [1:0] w_off;
  logic w_hit, w_unused;
  assign w_index = PC[INDEX_W+3:4];
  assign w_tag = PC[ADDR_W-1:INDEX_W+4];
  assign w_off = PC[3:2];
  assign w_unused = ^{PC[31:ADDR_W], PC[1:0]};
  assign w_miss_idx = r_miss[INDEX_W-1:0];
  assign w_hit = r_valid[w_index] && r_tag[w_index] == w_tag;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_hit ? S_IDLE : S_READ;
      S_READ:   w_next = MEM_BUSYWAIT ? S_READ : S_UPDATE;
      default:  w_next = S_IDLE;
    endcase
  end
  assign BUSYWAIT = !RESET && (r_state != S_IDLE || !w_hit);
  assign MEM_READ = !RESET && r_state == S_READ;
  assign MEM_ADDRESS = r_miss;
  assign INSTRUCTION = RESET ? 32'd0 : r_data[w_index][w_off];
  // Refill writes use only the latched miss address, so PC may wander meanwhile.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_miss <= '0;
      r_tag <= '{default: '0};
      r_data <= '{default: '0};
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && !w_hit) r_miss <= {w_tag, w_index};
      if (r_state == S_READ && !MEM_BUSYWAIT) begin
        r_data[w_miss_idx] <= MEM_READDATA;
        r_tag[w_miss_idx] <= r_miss[ADDR_W-5:INDEX_W];
        r_valid[w_miss_idx] <= 1'b1;
      end
    end
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_COUNT <= '0;
      MISS_COUNT <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_hit && HIT_COUNT != 16'hFFFF) HIT_COUNT <= HIT_COUNT + 16'd1;
      if (!w_hit && MISS_COUNT != 16'hFFFF) MISS_COUNT <= MISS_COUNT + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: fetch-level reference model of the cache plus a latency-programmable memory.
module tb_icache_fetch;
  logic CLK = 0, RESET = 1, MEM_BUSYWAIT = 1;
  logic [31:0] PC = 0, INSTRUCTION;
  logic BUSYWAIT, MEM_READ;
  logic [5:0] MEM_ADDRESS;
  logic [127:0] MEM_READDATA = 0;
`ifdef ICACHE_STATS_EN
  logic [15:0] HIT_COUNT, MISS_COUNT;
`endif
  icache_fetch dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );
  always #5 CLK = ~CLK;
  int total = 0, bad = 0, mem_lat = 1, mem_cnt = 0, n_hit = 0, n_miss = 0;
  bit m_valid [8];
  logic [2:0] m_tag [8];
  // Memory word at byte address a holds a itself, so any misplaced block shows up.
  function automatic logic [127:0] blk(input logic [5:0] a);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = {22'd0, a, k[1:0], 2'b00};
    return d;
  endfunction
  always @(posedge CLK) begin
    #2;
    if (MEM_READ) begin
      mem_cnt++;
      MEM_BUSYWAIT = mem_cnt < mem_lat;
      MEM_READDATA = blk(MEM_ADDRESS);
    end else begin
      mem_cnt = 0;
      MEM_BUSYWAIT = 1;
      MEM_READDATA = '0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    RESET = 1;
    #4;
    chk("rst_busy", {31'd0, BUSYWAIT}, 0);
    chk("rst_mread", {31'd0, MEM_READ}, 0);
    chk("rst_instr", INSTRUCTION, 0);
    @(posedge CLK); #1;
    RESET = 0;
    for (int i = 0; i < 8; i++) m_valid[i] = 0;
    n_hit = 0;
    n_miss = 0;
  endtask
  task automatic fetch(input logic [31:0] pc, input int l);
    logic [5:0] b;
    bit hit, addr_ok;
    int stalls, rd;
    b = pc[9:4];
    hit = m_valid[b[2:0]] && m_tag[b[2:0]] == b[5:3];
    PC = pc;
    mem_lat = l;
    stalls = 0;
    rd = 0;
    addr_ok = 1;
    #4;
    while (BUSYWAIT && stalls < 100) begin
      if (MEM_READ) begin
        rd++;
        if (MEM_ADDRESS !== b) addr_ok = 0;
      end
      stalls++;
      @(posedge CLK); #5;
    end
    chk("stall", stalls, hit ? 0 : l + 2);
    chk("mem_cycles", rd, hit ? 0 : l);
    if (!hit) chk("mem_addr", {31'd0, addr_ok}, 1);
    chk("mread_idle", {31'd0, MEM_READ}, 0);
    chk("instr", INSTRUCTION, pc & 32'h3FC);
    m_valid[b[2:0]] = 1;
    m_tag[b[2:0]] = b[5:3];
    n_hit++;
    if (!hit) n_miss++;
    @(posedge CLK); #1;
  endtask
  task automatic chk_stats();
`ifdef ICACHE_STATS_EN
    chk("hit_count", {16'd0, HIT_COUNT}, n_hit);
    chk("miss_count", {16'd0, MISS_COUNT}, n_miss);
`endif
  endtask
  initial begin
    @(posedge CLK); #1;
    do_reset();
    fetch(32'h0, 5);
    fetch(32'h4, 1);
    fetch(32'h8, 1);
    fetch(32'hC, 1);
    chk_stats();
    fetch(32'h80, 3);
    fetch(32'h0, 3);
    fetch(32'h400, 1);
    PC = 32'h1A0;
    mem_lat = 10;
    repeat (3) begin @(posedge CLK); #1; end
    #4;
    chk("abort_mread", {31'd0, MEM_READ}, 1);
    @(posedge CLK); #1;
    do_reset();
    fetch(32'h1A0, 2);
    fetch(32'h0, 2);
    for (int i = 0; i < 80; i++) fetch($urandom & 32'hFFFF_FCFF, $urandom_range(1, 4));
    chk_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
